// File: rtl/seq_bcd_display_if.sv
// Handshake and result bus for the sequential binary-to-display converter.
// The master requests conversions; the slave (the converter) returns results.
interface seq_bcd_display_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      data;
  logic                  hex_mode;
  logic                  blank_lz;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [4*DIGITS-1:0]   bcd;
  logic [7*DIGITS-1:0]   seg;

  modport master (
    output start, data, hex_mode, blank_lz,
    input  busy, done, overflow, bcd, seg
  );

  modport slave (
    input  start, data, hex_mode, blank_lz,
    output busy, done, overflow, bcd, seg
  );
endinterface

// File: rtl/seq_bcd_display.sv
// Sequential binary to BCD/hex converter with seven-segment output.
// Decimal uses one double-dabble step per cycle; hex is a direct load.
module seq_bcd_display #(
  parameter int WIDTH          = 8,
  parameter int DIGITS         = 3,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  seq_bcd_display_if.slave  bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int XW = (WIDTH > BW) ? WIDTH : BW;
  localparam logic [6:0] SEG_BLANK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD, FINISH} state_t;

  state_t              state, state_next;
  logic [WIDTH-1:0]    shreg;
  logic [BW-1:0]       scratch;
  logic                ovf_sticky;
  logic [CW-1:0]       cnt;
  logic                blz_q;
  logic                done_q;
  logic                ovf_q;
  logic [BW-1:0]       bcd_q;
  logic [7*DIGITS-1:0] seg_q;

  logic                accept;
  logic [BW-1:0]       adj;
  logic [XW:0]         ext;
  logic [7*DIGITS-1:0] seg_next;

  // Active-low {g,f,e,d,c,b,a} glyphs for 0..F.
  function automatic logic [6:0] seg_lut(input logic [3:0] d);
    case (d)
      4'h0: seg_lut = 7'b1000000;
      4'h1: seg_lut = 7'b1111001;
      4'h2: seg_lut = 7'b0100100;
      4'h3: seg_lut = 7'b0110000;
      4'h4: seg_lut = 7'b0011001;
      4'h5: seg_lut = 7'b0010010;
      4'h6: seg_lut = 7'b0000010;
      4'h7: seg_lut = 7'b1111000;
      4'h8: seg_lut = 7'b0000000;
      4'h9: seg_lut = 7'b0010000;
      4'hA: seg_lut = 7'b0001000;
      4'hB: seg_lut = 7'b0000011;
      4'hC: seg_lut = 7'b1000110;
      4'hD: seg_lut = 7'b0100001;
      4'hE: seg_lut = 7'b0000110;
      default: seg_lut = 7'b0001110;
    endcase
  endfunction

  assign accept = (state == IDLE) && bus.start;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = bus.hex_mode ? LOAD : SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_next = FINISH;
      LOAD:    state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Add-3 correction applied to every digit before the shift.
  always_comb begin
    adj = scratch;
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch[4*k +: 4] >= 4'd5) adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
    end
  end

  // One spare top bit keeps the overflow slice legal when WIDTH <= 4*DIGITS.
  assign ext = (XW + 1)'(shreg);

  always_comb begin
    logic any_nz;
    any_nz   = 1'b0;
    seg_next = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      any_nz = any_nz | (scratch[4*k +: 4] != 4'd0);
      if (blz_q && (k != 0) && !any_nz)
        seg_next[7*k +: 7] = SEG_BLANK;
      else
        seg_next[7*k +: 7] = SEG_ACTIVE_LOW ? seg_lut(scratch[4*k +: 4])
                                            : ~seg_lut(scratch[4*k +: 4]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      scratch    <= '0;
      ovf_sticky <= 1'b0;
      cnt        <= '0;
      blz_q      <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
      seg_q      <= {DIGITS{SEG_BLANK}};
    end else begin
      state  <= state_next;
      done_q <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          shreg      <= bus.data;
          blz_q      <= bus.blank_lz;
          scratch    <= '0;
          ovf_sticky <= 1'b0;
          cnt        <= CW'(WIDTH);
        end
        SHIFT: begin
          scratch    <= {adj[BW-2:0], shreg[WIDTH-1]};
          shreg      <= {shreg[WIDTH-2:0], 1'b0};
          ovf_sticky <= ovf_sticky | adj[BW-1];
          cnt        <= cnt - 1'b1;
        end
        LOAD: begin
          scratch    <= ext[BW-1:0];
          ovf_sticky <= |ext[XW:BW];
        end
        FINISH: begin
          bcd_q  <= scratch;
          seg_q  <= seg_next;
          ovf_q  <= ovf_sticky;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.bcd      = bcd_q;
  assign bus.seg      = seg_q;
endmodule

// File: tb/tb_seq_bcd_display.sv
// Directed bench for seq_bcd_display: an 8-bit/3-digit and a 16-bit/4-digit instance.
module tb_seq_bcd_display;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_bcd_display_if #(.WIDTH(8),  .DIGITS(3)) a_if ();
  seq_bcd_display_if #(.WIDTH(16), .DIGITS(4)) b_if ();

  seq_bcd_display #(.WIDTH(8), .DIGITS(3), .SEG_ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if.slave));
  seq_bcd_display #(.WIDTH(16), .DIGITS(4), .SEG_ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if.slave));

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0010000, SA = 7'b0001000, Sb = 7'b0000011;
  localparam logic [6:0] SC = 7'b1000110, Sd = 7'b0100001, SE = 7'b0000110, SF = 7'b0001110;
  localparam logic [6:0] BLK = 7'b1111111;

  typedef struct {
    logic [7:0]  data;
    logic        hex;
    logic        blz;
    logic [11:0] bcd;
    logic [20:0] seg;
    int          lat;
  } vec_a_t;

  typedef struct {
    logic [15:0] data;
    logic        hex;
    logic        blz;
    logic [15:0] bcd;
    logic [27:0] seg;
    logic        ovf;
    int          lat;
  } vec_b_t;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Start one conversion on instance A; returns edges from accept to done (-1 on timeout).
  task automatic run_a(input logic [7:0] d, input logic hex, input logic blz, output int lat);
    logic busy_ok;
    a_if.data = d; a_if.hex_mode = hex; a_if.blank_lz = blz; a_if.start = 1'b1;
    @(posedge clk); #1;
    a_if.start = 1'b0; a_if.data = ~d; a_if.hex_mode = ~hex; a_if.blank_lz = ~blz;
    busy_ok = a_if.busy;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (a_if.done) begin
        lat = n;
        check("a_busy_at_done", a_if.busy, 1'b0);
        break;
      end
      if (!a_if.busy) busy_ok = 1'b0;
    end
    check("a_busy_during", busy_ok, 1'b1);
  endtask

  task automatic run_b(input logic [15:0] d, input logic hex, input logic blz, output int lat);
    b_if.data = d; b_if.hex_mode = hex; b_if.blank_lz = blz; b_if.start = 1'b1;
    @(posedge clk); #1;
    b_if.start = 1'b0; b_if.data = ~d;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (b_if.done) begin lat = n; break; end
    end
  endtask

  vec_a_t va[14];
  vec_b_t vb[5];

  initial begin
    int lat, n1, n2, ndone;

    va[0]  = '{8'd255,  1'b0, 1'b0, 12'h255, {S2, S5, S5},   9};
    va[1]  = '{8'd0,    1'b0, 1'b1, 12'h000, {BLK, BLK, S0}, 9};
    va[2]  = '{8'hAF,   1'b1, 1'b1, 12'h0AF, {BLK, SA, SF},  2};
    va[3]  = '{8'd100,  1'b0, 1'b1, 12'h100, {S1, S0, S0},   9};
    va[4]  = '{8'd7,    1'b0, 1'b1, 12'h007, {BLK, BLK, S7}, 9};
    va[5]  = '{8'd42,   1'b0, 1'b0, 12'h042, {S0, S4, S2},   9};
    va[6]  = '{8'hFF,   1'b1, 1'b0, 12'h0FF, {S0, SF, SF},   2};
    va[7]  = '{8'h80,   1'b1, 1'b1, 12'h080, {BLK, S8, S0},  2};
    va[8]  = '{8'd196,  1'b0, 1'b0, 12'h196, {S1, S9, S6},   9};
    va[9]  = '{8'hCD,   1'b1, 1'b0, 12'h0CD, {S0, SC, Sd},   2};
    va[10] = '{8'hE3,   1'b1, 1'b0, 12'h0E3, {S0, SE, S3},   2};
    va[11] = '{8'hB6,   1'b1, 1'b1, 12'h0B6, {BLK, Sb, S6},  2};
    va[12] = '{8'd57,   1'b0, 1'b0, 12'h057, {S0, S5, S7},   9};
    va[13] = '{8'd0,    1'b1, 1'b0, 12'h000, {S0, S0, S0},   2};

    vb[0] = '{16'd65535, 1'b0, 1'b1, 16'h5535, {S5, S5, S3, S5},    1'b1, 17};
    vb[1] = '{16'd9999,  1'b0, 1'b0, 16'h9999, {S9, S9, S9, S9},    1'b0, 17};
    vb[2] = '{16'd10000, 1'b0, 1'b1, 16'h0000, {BLK, BLK, BLK, S0}, 1'b1, 17};
    vb[3] = '{16'hBEEF,  1'b1, 1'b0, 16'hBEEF, {Sb, SE, SE, SF},    1'b0, 2};
    vb[4] = '{16'd1234,  1'b0, 1'b1, 16'h1234, {S1, S2, S3, S4},    1'b0, 17};

    rst = 1'b1;
    a_if.start = 1'b0; a_if.data = '0; a_if.hex_mode = 1'b0; a_if.blank_lz = 1'b0;
    b_if.start = 1'b0; b_if.data = '0; b_if.hex_mode = 1'b0; b_if.blank_lz = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", a_if.busy, 1'b0);
    check("rst_done", a_if.done, 1'b0);
    check("rst_ovf",  a_if.overflow, 1'b0);
    check("rst_bcd",  a_if.bcd, 12'h000);
    check("rst_seg",  a_if.seg, {BLK, BLK, BLK});
    check("rst_b_seg", b_if.seg, {BLK, BLK, BLK, BLK});
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (va[i]) begin
      run_a(va[i].data, va[i].hex, va[i].blz, lat);
      check($sformatf("a%0d_lat", i), lat, va[i].lat);
      check($sformatf("a%0d_bcd", i), a_if.bcd, va[i].bcd);
      check($sformatf("a%0d_seg", i), a_if.seg, va[i].seg);
      check($sformatf("a%0d_ovf", i), a_if.overflow, 1'b0);
      @(posedge clk); #1;
      check($sformatf("a%0d_done_pulse", i), a_if.done, 1'b0);
      check($sformatf("a%0d_idle", i), a_if.busy, 1'b0);
    end

    foreach (vb[i]) begin
      run_b(vb[i].data, vb[i].hex, vb[i].blz, lat);
      check($sformatf("b%0d_lat", i), lat, vb[i].lat);
      check($sformatf("b%0d_bcd", i), b_if.bcd, vb[i].bcd);
      check($sformatf("b%0d_seg", i), b_if.seg, vb[i].seg);
      check($sformatf("b%0d_ovf", i), b_if.overflow, vb[i].ovf);
      @(posedge clk); #1;
    end

    // A second start three cycles into a conversion must be dropped.
    a_if.data = 8'd255; a_if.hex_mode = 1'b0; a_if.blank_lz = 1'b0; a_if.start = 1'b1;
    @(posedge clk); #1;
    a_if.start = 1'b0; a_if.data = 8'd0;
    repeat (2) begin @(posedge clk); #1; end
    a_if.start = 1'b1; a_if.data = 8'd1;
    @(posedge clk); #1;
    a_if.start = 1'b0;
    lat = -1;
    for (int n = 4; n <= 40; n++) begin
      @(posedge clk); #1;
      if (a_if.done) begin lat = n; break; end
    end
    check("ign_lat", lat, 9);
    check("ign_bcd", a_if.bcd, 12'h255);
    ndone = 0;
    repeat (15) begin @(posedge clk); #1; if (a_if.done) ndone++; end
    check("ign_no_second_done", ndone, 0);

    // start held high: one result every WIDTH+2 cycles.
    a_if.data = 8'd42; a_if.start = 1'b1;
    n1 = -1; n2 = -1;
    for (int n = 0; n <= 60; n++) begin
      @(posedge clk); #1;
      if (a_if.done) begin
        if (n1 < 0) n1 = n;
        else begin n2 = n; break; end
      end
    end
    a_if.start = 1'b0;
    check("held_first_done", n1, 9);
    check("held_second_done", n2, 19);
    check("held_bcd", a_if.bcd, 12'h042);
    @(posedge clk); #1;
    check("held_stops", a_if.busy, 1'b0);

    // Reset in the middle of SHIFT aborts with no done and clears the outputs.
    a_if.data = 8'd196; a_if.start = 1'b1;
    @(posedge clk); #1;
    a_if.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", a_if.busy, 1'b0);
    check("abort_done", a_if.done, 1'b0);
    check("abort_bcd",  a_if.bcd, 12'h000);
    check("abort_seg",  a_if.seg, {BLK, BLK, BLK});

    // rst and start on the same edge: rst wins.
    a_if.data = 8'd5; a_if.start = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    a_if.start = 1'b0; rst = 1'b0;
    check("rst_beats_start", a_if.busy, 1'b0);
    ndone = 0;
    repeat (12) begin @(posedge clk); #1; if (a_if.done || a_if.busy) ndone++; end
    check("abort_quiet", ndone, 0);

    run_a(8'd196, 1'b0, 1'b0, lat);
    check("fresh_lat", lat, 9);
    check("fresh_bcd", a_if.bcd, 12'h196);
    check("fresh_seg", a_if.seg, {S1, S9, S6});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
